// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Generates NUM_CH synchronous, active-high reset channels from an
//   asynchronous board reset and a clock-source lock indication. All channels
//   are held in reset for at least MIN_ASSERT clean cycles. They are then
//   released one at a time in ascending index order, STAGE_DLY cycles apart.
//   Loss of lock or a software reset request puts every channel back into
//   reset and restarts the sequence.
//
// Ports:
//   clk        in   single clock; every register uses its rising edge
//   arst       in   asynchronous, active-high reset
//   pll_locked in   clock-source lock, asynchronous to clk
//   sw_rst     in   synchronous, level-sensitive software reset request
//   srst       out  [NUM_CH] per-channel synchronous reset, active-high
//   srst_n     out  [NUM_CH] complement of srst, from its own register
//   rst_done   out  high once every channel is released
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int NUM_CH      = 4,   // 1..16
   parameter int SYNC_STAGES = 3,   // 2..8
   parameter int MIN_ASSERT  = 8,   // 1..1024
   parameter int STAGE_DLY   = 16   // 1..1024
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              pll_locked,
   input  logic              sw_rst,
   output logic [NUM_CH-1:0] srst,
   output logic [NUM_CH-1:0] srst_n,
   output logic              rst_done
);

   // The counter is sized for the longer of the two delays, plus one bit of
   // headroom. It is cleared at every terminal count, so it never wraps.
   localparam int MAX_DLY = (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
   localparam int CNT_W   = $clog2(MAX_DLY) + 1;

   localparam logic [CNT_W-1:0] MIN_TC   = CNT_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DLY - 1);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   // --------------------------------------------------------------------------
   // Reset synchroniser: asserts asynchronously and deasserts on the
   // SYNC_STAGES-th clock edge after arst falls.
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rst_meta;
   logic                   rst_sync;

   // NOTE: state is updated with non-blocking assignments. Every flop then
   // samples the pre-edge value of its neighbours, so the chain shifts by
   // exactly one stage per edge, whatever order the blocks are evaluated in.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rst_meta <= '1;
      end else begin
         rst_meta <= {rst_meta[SYNC_STAGES-2:0], 1'b0};
      end
   end

   assign rst_sync = rst_meta[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Lock synchroniser. It is cleared by the raw arst, so lock is never
   // reported until it has been seen after the reset.
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] lock_meta;
   logic                   locked_sync;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         lock_meta <= '0;
      end else begin
         lock_meta <= {lock_meta[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign locked_sync = lock_meta[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Sequencer
   // --------------------------------------------------------------------------
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               fault;
   logic [NUM_CH-1:0]  srst_shift;
   logic               last_release;

   assign fault = !locked_sync || sw_rst;

   // Channels are released in ascending order. The asserted channels are
   // therefore always a contiguous run of ones at the top of srst. Releasing
   // the next channel is a left shift. The final release is the shift that
   // leaves nothing asserted.
   assign srst_shift   = srst << 1;
   assign last_release = (srst_shift == '0);

   always_ff @(posedge clk or posedge rst_sync) begin
      if (rst_sync) begin
         state    <= HOLD;
         cnt      <= '0;
         srst     <= '1;
         srst_n   <= '0;
         rst_done <= 1'b0;
      end else if (fault) begin
         // Fault takes priority over any terminal count on the same edge.
         state    <= HOLD;
         cnt      <= '0;
         srst     <= '1;
         srst_n   <= '0;
         rst_done <= 1'b0;
      end else begin
         unique case (state)
            HOLD: begin
               if (cnt == MIN_TC) begin
                  cnt    <= '0;
                  srst   <= srst_shift;
                  srst_n <= ~srst_shift;
                  if (last_release) begin
                     state    <= RUN;
                     rst_done <= 1'b1;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RELEASE: begin
               if (cnt == STAGE_TC) begin
                  cnt    <= '0;
                  srst   <= srst_shift;
                  srst_n <= ~srst_shift;
                  if (last_release) begin
                     state    <= RUN;
                     rst_done <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RUN: begin
               // All channels released. Only a fault or rst_sync leaves this state.
            end

            default: begin
               state    <= HOLD;
               cnt      <= '0;
               srst     <= '1;
               srst_n   <= '0;
               rst_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_reset_sequencer;

   localparam int NUM  = 4;
   localparam int SYNC = 3;
   localparam int MINA = 8;
   localparam int STG  = 16;

   logic            clk = 1'b0;
   logic            arst = 1'b1;
   logic            pll_locked = 1'b1;
   logic            sw_rst = 1'b0;
   logic [NUM-1:0]  srst, srst_n;
   logic            rst_done;
   logic [0:0]      srst1, srst1_n;
   logic            rst_done1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   reset_sequencer #(.NUM_CH(NUM), .SYNC_STAGES(SYNC), .MIN_ASSERT(MINA), .STAGE_DLY(STG)) dut (
      .clk(clk), .arst(arst), .pll_locked(pll_locked), .sw_rst(sw_rst),
      .srst(srst), .srst_n(srst_n), .rst_done(rst_done)
   );

   reset_sequencer #(.NUM_CH(1), .SYNC_STAGES(SYNC), .MIN_ASSERT(1), .STAGE_DLY(1)) dut1 (
      .clk(clk), .arst(arst), .pll_locked(pll_locked), .sw_rst(sw_rst),
      .srst(srst1), .srst_n(srst1_n), .rst_done(rst_done1)
   );

   // ---------------------------------------------------------------------------
   // Reference model. m_clean counts the consecutive edges on which the
   // sequencer was out of reset and saw no fault. The number of released
   // channels follows from that count by arithmetic.
   // ---------------------------------------------------------------------------
   int             m_rst_edges = 0;
   bit [SYNC-1:0]  m_lock_hist = '0;
   int             m_clean = 0;

   function automatic int released(input int n, input int min_a, input int stg, input int num);
      int r;
      if (n < min_a) return 0;
      r = 1 + (n - min_a) / stg;
      return (r > num) ? num : r;
   endfunction

   function automatic logic [NUM-1:0] exp_srst();
      logic [NUM-1:0] ones;
      ones = '1;
      return ones << released(m_clean, MINA, STG, NUM);
   endfunction

   task automatic model_edge();
      if (arst) begin
         m_rst_edges = 0;
         m_lock_hist = '0;
         m_clean     = 0;
      end else begin
         if (m_rst_edges >= SYNC && m_lock_hist[SYNC-1] && !sw_rst)
            m_clean = (m_clean < 100000) ? m_clean + 1 : m_clean;
         else
            m_clean = 0;
         m_lock_hist = {m_lock_hist[SYNC-2:0], pll_locked};
         if (m_rst_edges < SYNC) m_rst_edges++;
      end
   endtask

   // Advance one clock. The model steps on the rising edge. The caller samples
   // on the falling edge and then drives new inputs.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      arst = 1'b1; pll_locked = 1'b1; sw_rst = 1'b0;
      ticks(4);
      vectors++;
      if (srst !== 4'b1111 || srst_n !== 4'b0000 || rst_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: srst=%b srst_n=%b done=%b expected 1111/0000/0", srst, srst_n, rst_done);
      end
      vectors++;
      if (srst1 !== 1'b1 || srst1_n !== 1'b0 || rst_done1 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_1ch: srst=%b srst_n=%b done=%b expected 1/0/0", srst1, srst1_n, rst_done1);
      end
   endtask

   // Release arst and check every edge against the fixed release schedule.
   task automatic run_sequence(input string tag);
      logic [NUM-1:0] e;
      arst = 1'b0;
      for (int edge_n = 1; edge_n <= 62; edge_n++) begin
         tick();
         e = {edge_n < 59, edge_n < 43, edge_n < 27, edge_n < 11};
         vectors++;
         if (srst !== e || srst_n !== ~e || rst_done !== (edge_n >= 59)) begin
            miscompares++;
            $display("FAIL %s edge %0d: srst=%b srst_n=%b done=%b expected %b/%b/%b",
                     tag, edge_n, srst, srst_n, rst_done, e, ~e, edge_n >= 59);
         end
         vectors++;
         if (srst1 !== (edge_n < 4) || srst1_n !== (edge_n >= 4) || rst_done1 !== (edge_n >= 4)) begin
            miscompares++;
            $display("FAIL %s_1ch edge %0d: srst=%b srst_n=%b done=%b expected %b/%b/%b",
                     tag, edge_n, srst1, srst1_n, rst_done1, edge_n < 4, edge_n >= 4, edge_n >= 4);
         end
      end
   endtask

   task automatic test_power_up();
      run_sequence("power_up");
   endtask

   task automatic test_async_arst();
      #2;
      arst = 1'b1;
      #1;
      vectors++;
      if (srst !== 4'b1111 || srst_n !== 4'b0000 || rst_done !== 1'b0) begin
         miscompares++;
         $display("FAIL async_arst: srst=%b srst_n=%b done=%b expected 1111/0000/0", srst, srst_n, rst_done);
      end
      vectors++;
      if (srst1 !== 1'b1 || rst_done1 !== 1'b0) begin
         miscompares++;
         $display("FAIL async_arst_1ch: srst=%b done=%b expected 1/0", srst1, rst_done1);
      end
      @(negedge clk);
      ticks(2);
      run_sequence("arst_restart");
   endtask

   task automatic test_pll_loss();
      pll_locked = 1'b0;
      ticks(2);
      vectors++;
      if (srst !== 4'b0000 || rst_done !== 1'b1) begin
         miscompares++;
         $display("FAIL pll_loss_early: srst=%b done=%b expected 0000/1", srst, rst_done);
      end
      ticks(2);
      vectors++;
      if (srst !== 4'b1111 || srst_n !== 4'b0000 || rst_done !== 1'b0) begin
         miscompares++;
         $display("FAIL pll_loss: srst=%b srst_n=%b done=%b expected 1111/0000/0", srst, srst_n, rst_done);
      end
      ticks(5);
      pll_locked = 1'b1;
      ticks(10);
      vectors++;
      if (srst !== 4'b1111) begin
         miscompares++;
         $display("FAIL relock_edge10: srst=%b expected 1111", srst);
      end
      tick();
      vectors++;
      if (srst !== 4'b1110 || srst_n !== 4'b0001) begin
         miscompares++;
         $display("FAIL relock_edge11: srst=%b srst_n=%b expected 1110/0001", srst, srst_n);
      end
      ticks(48);
      vectors++;
      if (srst !== 4'b0000 || rst_done !== 1'b1) begin
         miscompares++;
         $display("FAIL relock_run: srst=%b done=%b expected 0000/1", srst, rst_done);
      end
   endtask

   task automatic test_sw_rst_pulse();
      sw_rst = 1'b1;
      tick();
      sw_rst = 1'b0;
      ticks(24);
      vectors++;
      if (srst !== 4'b1100) begin
         miscompares++;
         $display("FAIL sw_pre: srst=%b expected 1100", srst);
      end
      sw_rst = 1'b1;
      tick();
      sw_rst = 1'b0;
      vectors++;
      if (srst !== 4'b1111 || srst_n !== 4'b0000 || rst_done !== 1'b0) begin
         miscompares++;
         $display("FAIL sw_pulse: srst=%b srst_n=%b done=%b expected 1111/0000/0", srst, srst_n, rst_done);
      end
      ticks(7);
      vectors++;
      if (srst !== 4'b1111) begin
         miscompares++;
         $display("FAIL sw_edge7: srst=%b expected 1111", srst);
      end
      tick();
      vectors++;
      if (srst !== 4'b1110) begin
         miscompares++;
         $display("FAIL sw_edge8: srst=%b expected 1110", srst);
      end
   endtask

   // Continues from test_sw_rst_pulse: srst[0] was released on edge 8 after
   // sw_rst fell, so the srst[2] terminal count falls on edge 40.
   task automatic test_fault_priority();
      ticks(31);
      vectors++;
      if (srst !== 4'b1100) begin
         miscompares++;
         $display("FAIL prio_pre: srst=%b expected 1100", srst);
      end
      sw_rst = 1'b1;
      tick();
      vectors++;
      if (srst !== 4'b1111 || srst_n !== 4'b0000 || rst_done !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_priority: srst=%b srst_n=%b done=%b expected 1111/0000/0", srst, srst_n, rst_done);
      end
   endtask

   task automatic test_sw_hold();
      sw_rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         vectors++;
         if (srst !== 4'b1111 || rst_done !== 1'b0 || srst1 !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_hold cycle %0d: srst=%b done=%b srst_1ch=%b expected 1111/0/1", i, srst, rst_done, srst1);
         end
      end
      sw_rst = 1'b0;
      ticks(7);
      vectors++;
      if (srst !== 4'b1111) begin
         miscompares++;
         $display("FAIL sw_hold_edge7: srst=%b expected 1111", srst);
      end
      tick();
      vectors++;
      if (srst !== 4'b1110) begin
         miscompares++;
         $display("FAIL sw_hold_edge8: srst=%b expected 1110", srst);
      end
   endtask

   task automatic test_random();
      int arst_left = 0, pll_left = 0, sw_left = 0;
      logic [NUM-1:0] e;
      logic e1;
      for (int i = 0; i < 4000; i++) begin
         if (arst_left > 0) arst_left--;
         else if ($urandom_range(399) == 0) arst_left = $urandom_range(3, 1);
         if (pll_left > 0) pll_left--;
         else if ($urandom_range(299) == 0) pll_left = $urandom_range(8, 1);
         if (sw_left > 0) sw_left--;
         else if ($urandom_range(249) == 0) sw_left = $urandom_range(4, 1);
         arst       = (arst_left > 0);
         pll_locked = (pll_left == 0);
         sw_rst     = (sw_left > 0);
         tick();
         e  = exp_srst();
         e1 = (released(m_clean, 1, 1, 1) == 0);
         vectors++;
         if (srst !== e || srst_n !== ~e || rst_done !== (e == '0)) begin
            miscompares++;
            $display("FAIL random cycle %0d: srst=%b srst_n=%b done=%b expected %b/%b/%b",
                     i, srst, srst_n, rst_done, e, ~e, e == '0);
         end
         vectors++;
         if (srst1 !== e1 || srst1_n !== !e1 || rst_done1 !== !e1) begin
            miscompares++;
            $display("FAIL random_1ch cycle %0d: srst=%b srst_n=%b done=%b expected %b/%b/%b",
                     i, srst1, srst1_n, rst_done1, e1, !e1, !e1);
         end
      end
      arst = 1'b0; pll_locked = 1'b1; sw_rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      @(negedge clk);
      test_reset();
      test_power_up();
      test_async_arst();
      test_pll_loss();
      test_sw_rst_pulse();
      test_fault_priority();
      test_sw_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
